rv_exec_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I integer subset: OP, OPIMM, BRANCH and LUI. It fetches one instruction at a time over a req/ack instruction-memory handshake and decodes it. It executes the instruction with a local ALU and an iterative 1-bit/cycle shifter, then writes back to an external register file and updates the PC. It sits between the instruction memory and the register file and is the sole owner of the PC.

---
 rtl/rv_exec_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_rv_exec_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_exec_sequencer.sv
// Multi-cycle RV32I (OP/OPIMM/BRANCH/LUI) fetch-decode-execute-writeback sequencer with a 1-bit/cycle shifter.
// Latency: 4 cycles per instruction minimum (FETCH, DECODE, EXEC, WB) + fetch wait cycles + shift amount.
// Backpressure: imem_req/imem_addr are held until imem_ack; no other stalls; TRAP halts until reset.
module rv_exec_sequencer #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            illegal
);

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_SHIFT  = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]     instr;
    logic [XLEN-1:0] sh_op;
    logic [4:0]      sh_cnt;
    logic            taken;

    // Instruction fields of the latched word
    logic [4:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_op;
    logic       is_opimm;
    logic       is_branch;
    logic       is_lui;

    assign opc       = instr[6:2];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign is_op     = (opc == OPC_OP);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_lui    = (opc == OPC_LUI);

    assign rs1_addr  = instr[19:15];
    assign rs2_addr  = instr[24:20];
    assign rd_addr   = instr[11:7];
    assign imem_addr = pc;

    // Immediates, sign-extended to XLEN
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] lui_val;

    assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_b   = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign lui_val = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};

    // Second ALU operand: immediate for OPIMM, rs2 for OP and BRANCH compares
    logic [XLEN-1:0] op_b;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    assign op_b = is_opimm ? imm_i : rs2_data;
    assign lt_s = ($signed(rs1_data) < $signed(op_b));
    assign lt_u = (rs1_data < op_b);
    assign eq   = (rs1_data == op_b);

    // Shift control: amount comes from rs2 for OP, from the instruction for OPIMM
    logic       is_shift;
    logic [4:0] shamt;
    logic       shift_go;
    logic       sh_left;
    logic       sh_arith;

    assign is_shift = (is_op || is_opimm) && ((funct3 == 3'b001) || (funct3 == 3'b101));
    assign shamt    = is_op ? rs2_data[4:0] : instr[24:20];
    assign shift_go = is_shift && (shamt != 5'd0);
    assign sh_left  = (funct3 == 3'b001);
    assign sh_arith = instr[30];

    // Branch target and misalignment
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc_plus4;
    logic            br_cond;
    logic            br_bad;

    assign br_target = pc + imm_b;
    assign pc_plus4  = pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign br_bad    = is_branch && br_cond && br_target[1];

    // Legality of the latched instruction
    logic legal;
    always_comb begin
        legal = 1'b0;
        if (instr[1:0] == 2'b11) begin
            if (is_op) begin
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end else if (is_opimm) begin
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    legal = 1'b1;
                end
            end else if (is_branch) begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end else if (is_lui) begin
                legal = 1'b1;
            end
        end
    end

    // Branch condition evaluation
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = !eq;
            3'b100:  br_cond = lt_s;
            3'b101:  br_cond = !lt_s;
            3'b110:  br_cond = lt_u;
            3'b111:  br_cond = !lt_u;
            default: br_cond = 1'b0;
        endcase
    end

    // Single-cycle ALU result; shifts fall through to rs1 (the shamt=0 result)
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] exec_res;
    always_comb begin
        alu_res = rs1_data;
        case (funct3)
            3'b000:  alu_res = (is_op && funct7[5]) ? (rs1_data - op_b) : (rs1_data + op_b);
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100:  alu_res = rs1_data ^ op_b;
            3'b110:  alu_res = rs1_data | op_b;
            3'b111:  alu_res = rs1_data & op_b;
            default: alu_res = rs1_data;
        endcase
    end

    assign exec_res = is_lui ? lui_val : alu_res;

    // One-bit step of the iterative shifter
    logic [XLEN-1:0] sh_next;
    always_comb begin
        sh_next = sh_op;
        if (sh_left) begin
            sh_next = {sh_op[XLEN-2:0], 1'b0};
        end else if (sh_arith) begin
            sh_next = {sh_op[XLEN-1], sh_op[XLEN-1:1]};
        end else begin
            sh_next = {1'b0, sh_op[XLEN-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (br_bad) begin
                    state_nxt = S_TRAP;
                end else if (shift_go) begin
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_SHIFT:  state_nxt = (sh_cnt == 5'd1) ? S_WB : S_SHIFT;
            S_WB:     state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output strobes decoded from the current state
    always_comb begin
        imem_req = 1'b0;
        rd_we    = 1'b0;
        retire   = 1'b0;
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_WB: begin
                retire = 1'b1;
                rd_we  = !is_branch && (rd_addr != 5'd0);
            end
            default: ;
        endcase
    end

    // Datapath registers: instruction latch, result, shifter, PC and trap flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr    <= 32'd0;
            rd_wdata <= {XLEN{1'b0}};
            sh_op    <= {XLEN{1'b0}};
            sh_cnt   <= 5'd0;
            taken    <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (state_nxt == S_TRAP) begin
                illegal <= 1'b1;
            end
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                    end
                end
                S_EXEC: begin
                    taken <= is_branch && br_cond;
                    if (shift_go) begin
                        sh_op  <= rs1_data;
                        sh_cnt <= shamt;
                    end else if (!is_branch) begin
                        rd_wdata <= exec_res;
                    end
                end
                S_SHIFT: begin
                    sh_op  <= sh_next;
                    sh_cnt <= sh_cnt - 5'd1;
                    if (sh_cnt == 5'd1) begin
                        rd_wdata <= sh_next;
                    end
                end
                S_WB: begin
                    pc <= taken ? br_target : pc_plus4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_exec_sequencer.sv
// Randomized + directed bench for rv_exec_sequencer with an ISA-level reference model.
// Stimulus pushes expected write-back/next-pc into a queue; a monitor pops on every retire.
// Instruction memory and register file are modelled here with random ack delays.
module tb_rv_exec_sequencer;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc;
    logic        retire;
    logic        illegal;

    logic [31:0] rf [32];

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

    rv_exec_sequencer #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .pc(pc), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          trap;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] npc;
        int          lat;
        int          ack_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    int          done_cnt = 0;
    bit          pc_chk_pending = 0;
    logic [31:0] pc_exp_next;
    logic [31:0] mpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // ISA-level reference: result of one instruction given pc and register values
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] cur_pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] immi;
        logic [31:0] bb;
        logic [31:0] off;
        logic [31:0] tgt;
        int          sh;
        bit          isop;
        bit          cond;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        immi = {{20{ins[31]}}, ins[31:20]};
        e.trap = 0;
        e.rd   = ins[11:7];
        e.we   = (ins[11:7] != 5'd0);
        e.wd   = 32'd0;
        e.npc  = cur_pc + 32'd4;
        e.lat  = 3;
        e.ack_cyc = 0;
        case (op)
            7'h33, 7'h13: begin
                isop = (op == 7'h33);
                bb   = isop ? b : immi;
                sh   = isop ? int'(b[4:0]) : int'(ins[24:20]);
                if (isop && !(f7 == 7'h00 || f7 == 7'h20)) e.trap = 1;
                if (isop && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) e.trap = 1;
                if (!isop && f3 == 3'd1 && f7 != 7'h00) e.trap = 1;
                if (!isop && f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) e.trap = 1;
                case (f3)
                    3'd0: begin
                        if (isop && f7 == 7'h20) e.wd = a - bb;
                        else e.wd = a + bb;
                    end
                    3'd1: e.wd = a << sh;
                    3'd2: e.wd = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
                    3'd3: e.wd = (a < bb) ? 32'd1 : 32'd0;
                    3'd4: e.wd = a ^ bb;
                    3'd5: begin
                        if (f7 == 7'h20) e.wd = $signed(a) >>> sh;
                        else e.wd = a >> sh;
                    end
                    3'd6: e.wd = a | bb;
                    default: e.wd = a & bb;
                endcase
                if (f3 == 3'd1 || f3 == 3'd5) e.lat = 3 + sh;
            end
            7'h37: e.wd = {ins[31:12], 12'd0};
            7'h63: begin
                e.we = 0;
                cond = 0;
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = ($signed(a) < $signed(b));
                    3'd5: cond = ($signed(a) >= $signed(b));
                    3'd6: cond = (a < b);
                    3'd7: cond = (a >= b);
                    default: e.trap = 1;
                endcase
                off = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                tgt = cur_pc + off;
                if (cond) begin
                    if (tgt[1]) e.trap = 1;
                    e.npc = tgt;
                end
            end
            default: e.trap = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        logic [12:0] im;
        im = off[12:0];
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] gen_rand();
        logic [4:0]  rd, rs1, rs2, sa;
        logic [2:0]  f3;
        logic [31:0] u;
        logic [6:0]  f7;
        int          off;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        sa  = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        u   = $urandom();
        case ($urandom_range(0, 3))
            0: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_r(f7, rs2, rs1, f3, rd);
            end
            1: begin
                if (f3 == 3'd1) return enc_i({7'h00, sa}, rs1, f3, rd);
                if (f3 == 3'd5) return enc_i({($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, sa}, rs1, f3, rd);
                return enc_i(u[11:0], rs1, f3, rd);
            end
            2: return {u[19:0], rd, 7'h37};
            default: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd4;
                    3: f3 = 3'd5;
                    4: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
                off = (int'($urandom_range(0, 32)) - 16) * 4;
                return enc_b(off, rs2, rs1, f3);
            end
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        imem_ack = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_rd_we", rd_we, 1'b0);
        chk("rst_retire", retire, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_rd_wdata", rd_wdata, 32'd0);
        exp_q.delete();
        issued = done_cnt;
        mpc = RST_PC;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one instruction: set registers, serve the fetch, then wait for retire or check the trap
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] v1, input logic [31:0] v2,
                             input int dly, input int abort_after);
        exp_t        e;
        logic [31:0] a, b;
        int          budget;
        for (int i = 1; i < 32; i++) rf[i] = $urandom();
        if (ins[24:20] != 5'd0) rf[ins[24:20]] = v2;
        if (ins[19:15] != 5'd0) rf[ins[19:15]] = v1;
        a = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
        b = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
        e = model(ins, mpc, a, b);

        budget = 20;
        @(negedge clk);
        while (!imem_req) begin
            budget--;
            if (budget == 0) timeout("wait_imem_req");
            @(negedge clk);
        end
        chk("imem_addr", imem_addr, mpc);
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            chk("fetch_hold_req", imem_req, 1'b1);
            chk("fetch_hold_addr", imem_addr, mpc);
        end
        imem_ack = 1'b1;
        imem_rdata = ins;
        e.ack_cyc = cyc;
        if (!e.trap && abort_after == 0) begin
            exp_q.push_back(e);
            issued++;
        end
        @(negedge clk);
        imem_rdata = $urandom();
        @(negedge clk);
        imem_ack = 1'b0;

        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            do_reset();
        end else if (e.trap) begin
            repeat (6) begin
                @(negedge clk);
                chk("trap_illegal", illegal, 1'b1);
                chk("trap_imem_req", imem_req, 1'b0);
                chk("trap_pc", pc, mpc);
            end
        end else begin
            budget = 80;
            while (done_cnt != issued) begin
                budget--;
                if (budget == 0) timeout("wait_retire");
                @(negedge clk);
            end
            chk("no_illegal", illegal, 1'b0);
            mpc = e.npc;
        end
    endtask

    // Monitor: pops an expectation on every retire and checks the following pc
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (pc_chk_pending) begin
                chk("pc_after_wb", pc, pc_exp_next);
                pc_chk_pending = 0;
                done_cnt++;
            end
            if (rd_we && !retire) chk("stray_rd_we", rd_we, 1'b0);
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", retire, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_we", rd_we, e.we);
                    if (e.we) begin
                        chk("rd_addr", rd_addr, e.rd);
                        chk("rd_wdata", rd_wdata, e.wd);
                    end
                    chk("latency", cyc - e.ack_cyc, e.lat);
                    pc_exp_next = e.npc;
                    pc_chk_pending = 1;
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        mpc = RST_PC;
        do_reset();
        // Straight-line code crossing the pc wrap at 0xFFFF_FFFC
        run_instr(32'h0050_0093, 32'd0, 32'd0, 0, 0);                      // ADDI x1,x0,5
        run_instr(enc_i(12'd31, 5'd1, 3'd1, 5'd2), 32'd1, 32'd0, 1, 0);    // SLLI x2,x1,31
        run_instr(enc_i(12'h404, 5'd1, 3'd5, 5'd3), 32'h8000_0000, 32'd0, 2, 0); // SRAI x3,x1,4
        run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), $urandom(), $urandom(), 0, 0); // ADD at 0xFFFFFFFC
        run_instr(enc_i(12'd0, 5'd1, 3'd1, 5'd6), 32'hDEAD_BEEF, 32'd0, 0, 0);  // SLLI by 0
        run_instr(32'h1234_52B7, 32'd0, 32'd0, 0, 0);                      // LUI x5,0x12345
        run_instr(32'h1234_5037, 32'd0, 32'd0, 0, 0);                      // LUI x0
        run_instr(32'h0050_0093, 32'd0, 32'd0, 3, 0);                      // delayed ack
        // Branches starting at pc=0x10
        run_instr(enc_b(-8, 5'd0, 5'd0, 3'd0), 32'd0, 32'd0, 0, 0);        // BEQ taken -> 0x08
        run_instr(enc_b(12, 5'd7, 5'd6, 3'd1), 32'h55, 32'h55, 0, 0);      // BNE equal -> 0x0C
        run_instr(enc_b(64, 5'd7, 5'd6, 3'd6), 32'hFFFF_FFFF, 32'd1, 0, 0); // BLTU not taken -> 0x10
        run_instr(enc_b(16, 5'd6, 5'd6, 3'd5), 32'h1234, 32'h1234, 0, 0);  // BGE same reg taken -> 0x20
        run_instr(enc_b(-16, 5'd7, 5'd6, 3'd4), 32'hFFFF_FFFB, 32'd3, 1, 0); // BLT -5<3 -> 0x10
        run_instr(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd8), 32'd10, 32'd13, 0, 0); // SUB
        // Random legal traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] v1, v2;
            v1 = $urandom();
            v2 = ($urandom_range(0, 3) == 0) ? v1 : $urandom();
            run_instr(gen_rand(), v1, v2, int'($urandom_range(0, 3)), 0);
        end
        // Reset in the middle of a long shift, then refetch from RESET_PC
        run_instr(enc_i(12'd31, 5'd1, 3'd1, 5'd2), 32'd1, 32'd0, 0, 10);
        run_instr(32'h0050_0093, 32'd0, 32'd0, 0, 0);
        // Illegal encodings and a misaligned taken branch, each followed by reset
        run_instr(32'h0000_0000, 32'd0, 32'd0, 0, 0);
        do_reset();
        run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd3), 32'd1, 32'd2, 1, 0);
        do_reset();
        run_instr(enc_i(12'h402, 5'd1, 3'd1, 5'd3), 32'd1, 32'd0, 0, 0);  // SLLI funct7!=0
        do_reset();
        run_instr(enc_b(8, 5'd2, 5'd1, 3'd2), 32'd1, 32'd2, 0, 0);         // BRANCH funct3=010
        do_reset();
        run_instr(32'h0000_006F, 32'd0, 32'd0, 0, 0);                      // JAL: unsupported opcode
        do_reset();
        run_instr(enc_b(2, 5'd0, 5'd0, 3'd0), 32'd0, 32'd0, 0, 0);         // BEQ +2 misaligned
        do_reset();
        run_instr(32'h0050_0093, 32'd0, 32'd0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
